// File: rtl/ram8_arbiter_pkg.sv
// Shared definitions for the two-port ram8 arbiter: FSM state encoding and
// default geometry of the shared ram8.
package ram8_arbiter_pkg;

    localparam int unsigned AW_DEF = 3;
    localparam int unsigned DW_DEF = 16;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/ram8_arbiter_if.sv
// Requester handshakes plus the ram8 pin bundle seen by the arbiter.
// slave  : the arbiter's view (takes requests, drives the ram8 pins).
// master : the surrounding system's view (requesters and the ram8 itself).
interface ram8_arbiter_if
    import ram8_arbiter_pkg::*;
#(
    parameter int unsigned AW = AW_DEF,
    parameter int unsigned DW = DW_DEF
) ();

    logic          req0;
    logic          we0;
    logic [AW-1:0] adr0;
    logic [DW-1:0] wdata0;
    logic          ack0;
    logic [DW-1:0] rdata0;

    logic          req1;
    logic          we1;
    logic [AW-1:0] adr1;
    logic [DW-1:0] wdata1;
    logic          ack1;
    logic [DW-1:0] rdata1;

    logic [AW-1:0] ram_adr;
    logic [DW-1:0] ram_data;
    logic          ram_load;
    logic [DW-1:0] ram_out;

    modport slave (
        input  req0, we0, adr0, wdata0,
        input  req1, we1, adr1, wdata1,
        input  ram_out,
        output ack0, rdata0, ack1, rdata1,
        output ram_adr, ram_data, ram_load
    );

    modport master (
        output req0, we0, adr0, wdata0,
        output req1, we1, adr1, wdata1,
        output ram_out,
        input  ack0, rdata0, ack1, rdata1,
        input  ram_adr, ram_data, ram_load
    );

endinterface

// File: rtl/ram8_arbiter_rr_pick2.sv
// Two-way round-robin pick. A masked requester is ignored; when both
// remaining requesters are active the one that was not served last wins.
module rr_pick2 (
    input  logic req0,
    input  logic req1,
    input  logic last,
    input  logic mask_en,
    input  logic mask_id,
    output logic valid,
    output logic winner
);

    logic eff0;
    logic eff1;

    // Apply the mask, then resolve contention against the last-served id.
    always_comb begin
        eff0   = req0 & ~(mask_en & ~mask_id);
        eff1   = req1 & ~(mask_en &  mask_id);
        valid  = eff0 | eff1;
        winner = (eff0 & eff1) ? ~last : eff1;
    end

endmodule

// File: rtl/ram8_arbiter.sv
// Round-robin arbiter giving two requesters single-access turns on a shared
// ram8 (registered write, combinational read). Each access is one BUSY cycle
// followed by one DONE cycle carrying the ack pulse.
module ram8_arbiter
    import ram8_arbiter_pkg::*;
#(
    parameter int unsigned AW = AW_DEF,
    parameter int unsigned DW = DW_DEF
) (
    input  logic           clk,
    input  logic           reset,
    ram8_arbiter_if.slave  bus
);

    state_t        state_q, state_d;
    logic          owner_q, owner_d;
    logic          last_q,  last_d;
    logic          ack0_q,  ack0_d;
    logic          ack1_q,  ack1_d;
    logic [DW-1:0] rdata0_q, rdata0_d;
    logic [DW-1:0] rdata1_q, rdata1_d;

    logic          own_we;
    logic [AW-1:0] own_adr;
    logic [DW-1:0] own_wdata;
    logic          mask_en;
    logic          pick_valid;
    logic          pick_winner;

    // The requester just served cannot win again straight out of DONE.
    assign mask_en = (state_q == ST_DONE);

    rr_pick2 u_pick (
        .req0    (bus.req0),
        .req1    (bus.req1),
        .last    (last_q),
        .mask_en (mask_en),
        .mask_id (owner_q),
        .valid   (pick_valid),
        .winner  (pick_winner)
    );

    // Select the owner's request fields; they stay on the ram pins after BUSY.
    always_comb begin
        own_we    = owner_q ? bus.we1    : bus.we0;
        own_adr   = owner_q ? bus.adr1   : bus.adr0;
        own_wdata = owner_q ? bus.wdata1 : bus.wdata0;
    end

    // Reset gates load directly so a write caught mid-BUSY never commits.
    always_comb begin
        bus.ram_adr  = own_adr;
        bus.ram_data = own_wdata;
        bus.ram_load = (state_q == ST_BUSY) && own_we && !reset;
        bus.ack0     = ack0_q;
        bus.ack1     = ack1_q;
        bus.rdata0   = rdata0_q;
        bus.rdata1   = rdata1_q;
    end

    // FSM next state: grant in IDLE/DONE, complete the access in BUSY.
    always_comb begin
        state_d  = state_q;
        owner_d  = owner_q;
        last_d   = last_q;
        ack0_d   = 1'b0;
        ack1_d   = 1'b0;
        rdata0_d = rdata0_q;
        rdata1_d = rdata1_q;
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (pick_valid) begin
                    state_d = ST_BUSY;
                    owner_d = pick_winner;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_BUSY: begin
                state_d = ST_DONE;
                last_d  = owner_q;
                if (owner_q) begin
                    ack1_d = 1'b1;
                    if (!own_we) rdata1_d = bus.ram_out;
                end else begin
                    ack0_d = 1'b1;
                    if (!own_we) rdata0_d = bus.ram_out;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Register FSM state, arbitration history and the registered outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            owner_q  <= 1'b0;
            last_q   <= 1'b1;
            ack0_q   <= 1'b0;
            ack1_q   <= 1'b0;
            rdata0_q <= '0;
            rdata1_q <= '0;
        end else begin
            state_q  <= state_d;
            owner_q  <= owner_d;
            last_q   <= last_d;
            ack0_q   <= ack0_d;
            ack1_q   <= ack1_d;
            rdata0_q <= rdata0_d;
            rdata1_q <= rdata1_d;
        end
    end

endmodule
